coprocessor_io_riscv_ctrl: RTL and testbench
============================================

COPROCESSOR_IO_RISCV_CTRL -- requirements
Module: coprocessor_io_riscv_ctrl

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 4: cycles cop_reset_n is held low per reset pulse.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth on cop_flags.
REQ-003 SHALL have port clk, input, 1: single clock for all logic.
REQ-004 SHALL have port reset_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port chipselect, input, 1: Avalon-MM slave select.
REQ-006 SHALL have port address, input, 2: register index (0 CTRL, 1 STATUS, 2 TIMEOUT, 3 CYCLES).
REQ-007 SHALL have port write_n, input, 1: active-low write strobe, valid with chipselect.
REQ-008 SHALL have port writedata, input, 32: write data.
REQ-009 SHALL have port readdata, output, 32: registered read data.
REQ-010 SHALL have port irq, output, 1: level interrupt to Nios.
REQ-011 SHALL have port cop_flags, input, 2: bit0 done, bit1 error, asynchronous to clk.
REQ-012 SHALL have port cop_reset_n, output, 1: active-low reset to RISC-V coprocessor.
REQ-013 SHALL have port cop_start, output, 1: one-cycle start pulse to coprocessor.

Function
REQ-014 SHALL decode a write when chipselect=1 and write_n=0, with zero wait states.
REQ-015 SHALL update readdata every clk with the addressed register (unused bits 0), giving 1-cycle read latency.
REQ-016 CTRL write: bit0 START (no storage, reads 0), bit1 ABORT (no storage, reads 0), bit2 IRQ_EN (stored, reads back).
REQ-017 STATUS read: bit0 busy, bit1 done, bit2 timeout, bit3 error, bits5:4 synchronized cop_flags; bits1..3 write-1-to-clear.
REQ-018 TIMEOUT: 32-bit RW limit in clk cycles; 0 disables timeout.
REQ-019 CYCLES: read-only 32-bit count of cycles spent in RUN, cleared on entry to PULSE, saturating at 0xFFFFFFFF.
REQ-020 FSM states SHALL be IDLE, PULSE, START, RUN, ABORT.
REQ-021 IDLE + START write -> PULSE: clear done/timeout/error, drive cop_reset_n=0 for RST_CYCLES cycles, then -> START.
REQ-022 START: cop_start=1 for exactly one cycle, then -> RUN.
REQ-023 RUN: sync flag bit1=1 -> set error, -> ABORT; else bit0=1 -> set done, -> IDLE; else CYCLES+1==TIMEOUT (TIMEOUT!=0) -> set timeout, -> ABORT.
REQ-024 Error and done in the same cycle SHALL record error only.
REQ-025 ABORT: cop_reset_n=0 for RST_CYCLES cycles, then -> IDLE; no cop_start.
REQ-026 ABORT write SHALL force ABORT from PULSE, START or RUN; ignored in IDLE and ABORT.
REQ-027 START write outside IDLE SHALL be ignored; START+ABORT in one write: ABORT wins (IDLE: no action).
REQ-028 busy SHALL be 1 in every state except IDLE.
REQ-029 A W1C clear in the same cycle as a set of that bit: set wins.
REQ-030 irq SHALL equal IRQ_EN & (done | timeout | error), registered.
REQ-031 cop_flags SHALL pass through SYNC_STAGES flip-flops before any use.

Reset
REQ-032 On reset_n=0: state IDLE, readdata 0, irq 0, cop_start 0, cop_reset_n 0, IRQ_EN 0, TIMEOUT 0, CYCLES 0, status bits 0, synchronizers 0.
REQ-033 cop_reset_n SHALL rise to 1 on the first clk after reset_n release (in IDLE).

Structure
REQ-034 Shared package SHALL hold the state enum, register address constants, and CTRL/STATUS bit positions.
REQ-035 Flag synchronizer SHALL be one sub-module, coprocessor_io_riscv_sync.

Verification
REQ-036 TIMEOUT=0, write CTRL=0x5, cop_flags=01 at RUN+10 -> cop_reset_n low 4 cycles, one cop_start, done=1, CYCLES≈10, irq=1.
REQ-037 TIMEOUT=20, flags stay 00 -> timeout=1 after 20 RUN cycles, ABORT reset pulse 4 cycles, CYCLES=20.
REQ-038 cop_flags=11 in RUN -> error=1, done=0, ABORT entered.
REQ-039 CTRL=0x1 during RUN -> ignored; CTRL=0x3 during RUN -> ABORT, no new cop_start.
REQ-040 STATUS write 0x2 while done=1 -> done=0, irq=0; reset_n pulsed mid-RUN -> all REQ-032 values.

Source files
------------

// File: rtl/coprocessor_io_riscv_ctrl_pkg.sv
// Shared types and constants for the Nios-side RISC-V coprocessor controller.
// Holds the FSM state encoding, register map and register bit positions.
package coprocessor_io_riscv_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PULSE = 3'd1,
        ST_START = 3'd2,
        ST_RUN   = 3'd3,
        ST_ABORT = 3'd4
    } state_t;

    localparam logic [1:0] ADDR_CTRL    = 2'd0;
    localparam logic [1:0] ADDR_STATUS  = 2'd1;
    localparam logic [1:0] ADDR_TIMEOUT = 2'd2;
    localparam logic [1:0] ADDR_CYCLES  = 2'd3;

    localparam int CTRL_START  = 0;
    localparam int CTRL_ABORT  = 1;
    localparam int CTRL_IRQ_EN = 2;

    localparam int STS_BUSY    = 0;
    localparam int STS_DONE    = 1;
    localparam int STS_TIMEOUT = 2;
    localparam int STS_ERROR   = 3;
    localparam int STS_FLAGS   = 4;

    localparam int FLAG_DONE  = 0;
    localparam int FLAG_ERROR = 1;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/coprocessor_io_riscv_sync.sv
// Multi-flop synchronizer bringing the coprocessor status flags into clk.
// Depth is a parameter; all stages clear on reset.
module coprocessor_io_riscv_sync #(
    parameter int STAGES = 2,
    parameter int WIDTH  = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync
);

    logic [WIDTH-1:0] r_stage [STAGES];

    // shift the asynchronous flags through the flop chain
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_async;
            for (int i = 1; i < STAGES; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_sync = r_stage[STAGES-1];

endmodule

// File: rtl/coprocessor_io_riscv_ctrl.sv
// Avalon-MM slave that resets, starts and supervises a RISC-V coprocessor.
// Tracks done/error/timeout, counts RUN cycles and raises a level irq.
module coprocessor_io_riscv_ctrl
    import coprocessor_io_riscv_ctrl_pkg::*;
#(
    parameter int RST_CYCLES  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        chipselect,
    input  logic [1:0]  address,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        irq,
    input  logic [1:0]  cop_flags,
    output logic        cop_reset_n,
    output logic        cop_start
);

    localparam int CW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(RST_CYCLES - 1);

    state_t r_state;
    state_t w_next;

    logic [CW-1:0] r_cnt;
    logic [31:0]   r_timeout_lim;
    logic [31:0]   r_cycles;
    logic [31:0]   r_readdata;
    logic [31:0]   w_rdata;
    logic [1:0]    w_flags;

    logic r_irq_en;
    logic r_done;
    logic r_timeout;
    logic r_error;
    logic r_irq;
    logic r_cop_start;
    logic r_cop_reset_n;

    logic w_wr;
    logic w_wr_ctrl;
    logic w_w1c;
    logic w_start_req;
    logic w_abort_req;
    logic w_run_entry;
    logic w_cnt_last;
    logic w_tmo_hit;
    logic w_busy;
    logic w_set_done;
    logic w_set_to;
    logic w_set_err;

    coprocessor_io_riscv_sync #(
        .STAGES(SYNC_STAGES),
        .WIDTH (2)
    ) u_sync (
        .i_clk  (clk),
        .i_rst_n(reset_n),
        .i_async(cop_flags),
        .o_sync (w_flags)
    );

    assign w_wr        = chipselect & ~write_n;
    assign w_wr_ctrl   = w_wr & (address == ADDR_CTRL);
    assign w_w1c       = w_wr & (address == ADDR_STATUS);
    assign w_start_req = w_wr_ctrl & writedata[CTRL_START]
                       & ~writedata[CTRL_ABORT];
    assign w_abort_req = w_wr_ctrl & writedata[CTRL_ABORT];
    assign w_run_entry = (r_state == ST_IDLE) & w_start_req;
    assign w_cnt_last  = (r_cnt == CNT_LAST);
    assign w_tmo_hit   = (r_timeout_lim != 32'd0)
                       & ((r_cycles + 32'd1) == r_timeout_lim);
    assign w_busy      = (r_state != ST_IDLE);

    // next-state decode and one-cycle status set strobes
    always_comb begin
        w_next     = r_state;
        w_set_done = 1'b0;
        w_set_to   = 1'b0;
        w_set_err  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_start_req) w_next = ST_PULSE;
            end
            ST_PULSE: begin
                if (w_abort_req)     w_next = ST_ABORT;
                else if (w_cnt_last) w_next = ST_START;
            end
            ST_START: begin
                if (w_abort_req) w_next = ST_ABORT;
                else             w_next = ST_RUN;
            end
            ST_RUN: begin
                if (w_abort_req) begin
                    w_next = ST_ABORT;
                end else if (w_flags[FLAG_ERROR]) begin
                    w_set_err = 1'b1;
                    w_next    = ST_ABORT;
                end else if (w_flags[FLAG_DONE]) begin
                    w_set_done = 1'b1;
                    w_next     = ST_IDLE;
                end else if (w_tmo_hit) begin
                    w_set_to = 1'b1;
                    w_next   = ST_ABORT;
                end
            end
            ST_ABORT: begin
                if (w_cnt_last) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // state register and reset-pulse length counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state != w_next) r_cnt <= '0;
            else if (w_busy)       r_cnt <= r_cnt + 1'b1;
        end
    end

    // registered coprocessor controls, aligned with the state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cop_reset_n <= 1'b0;
            r_cop_start   <= 1'b0;
        end else begin
            r_cop_reset_n <= (w_next != ST_PULSE) && (w_next != ST_ABORT);
            r_cop_start   <= (w_next == ST_START);
        end
    end

    // writable configuration: irq enable and timeout limit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irq_en      <= 1'b0;
            r_timeout_lim <= 32'd0;
        end else begin
            if (w_wr_ctrl) r_irq_en <= writedata[CTRL_IRQ_EN];
            if (w_wr && address == ADDR_TIMEOUT) r_timeout_lim <= writedata;
        end
    end

    // sticky status bits: set beats W1C, cleared on a new run
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_done    <= w_set_done | (r_done & ~w_run_entry
                       & ~(w_w1c & writedata[STS_DONE]));
            r_timeout <= w_set_to | (r_timeout & ~w_run_entry
                       & ~(w_w1c & writedata[STS_TIMEOUT]));
            r_error   <= w_set_err | (r_error & ~w_run_entry
                       & ~(w_w1c & writedata[STS_ERROR]));
        end
    end

    // saturating RUN cycle counter, cleared when a new run begins
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cycles <= 32'd0;
        end else if (w_run_entry) begin
            r_cycles <= 32'd0;
        end else if (r_state == ST_RUN) begin
            r_cycles <= sat_inc(r_cycles);
        end
    end

    // read mux over the register map
    always_comb begin
        w_rdata = 32'd0;
        unique case (address)
            ADDR_CTRL: begin
                w_rdata[CTRL_IRQ_EN] = r_irq_en;
            end
            ADDR_STATUS: begin
                w_rdata[STS_BUSY]             = w_busy;
                w_rdata[STS_DONE]             = r_done;
                w_rdata[STS_TIMEOUT]          = r_timeout;
                w_rdata[STS_ERROR]            = r_error;
                w_rdata[STS_FLAGS+1:STS_FLAGS] = w_flags;
            end
            ADDR_TIMEOUT: w_rdata = r_timeout_lim;
            ADDR_CYCLES:  w_rdata = r_cycles;
            default:      w_rdata = 32'd0;
        endcase
    end

    // registered read data and interrupt
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_readdata <= 32'd0;
            r_irq      <= 1'b0;
        end else begin
            r_readdata <= w_rdata;
            r_irq      <= r_irq_en & (r_done | r_timeout | r_error);
        end
    end

    assign readdata    = r_readdata;
    assign irq         = r_irq;
    assign cop_reset_n = r_cop_reset_n;
    assign cop_start   = r_cop_start;

endmodule

// File: tb/tb_coprocessor_io_riscv_ctrl.sv
// Randomized self-checking bench for coprocessor_io_riscv_ctrl.
// Expected outcomes come from a run-level timing model of the controller.
module tb_coprocessor_io_riscv_ctrl;

    localparam int RST  = 4;
    localparam int SYNC = 2;
    localparam logic [1:0] A_CTRL = 2'd0;
    localparam logic [1:0] A_STS  = 2'd1;
    localparam logic [1:0] A_TMO  = 2'd2;
    localparam logic [1:0] A_CYC  = 2'd3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        chipselect = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic        irq;
    logic [1:0]  cop_flags = 2'b00;
    logic        cop_reset_n;
    logic        cop_start;

    int total = 0;
    int bad = 0;
    int n_start = 0;
    int low_run = 0;
    int q_low[$];

    coprocessor_io_riscv_ctrl #(
        .RST_CYCLES (RST),
        .SYNC_STAGES(SYNC)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .chipselect (chipselect),
        .address    (address),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq),
        .cop_flags  (cop_flags),
        .cop_reset_n(cop_reset_n),
        .cop_start  (cop_start)
    );

    always #5 clk = ~clk;

    // record start pulses and the length of every cop_reset_n low period
    always @(negedge clk) begin
        if (!reset_n) begin
            low_run = 0;
        end else begin
            if (cop_start === 1'b1) n_start++;
            if (cop_reset_n === 1'b0) begin
                low_run++;
            end else if (low_run > 0) begin
                q_low.push_back(low_run);
                low_run = 0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b1;
        address    = a;
        @(posedge clk);
        #1;
        d = readdata;
        chipselect = 1'b0;
    endtask

    task automatic test_reset;
        logic [31:0] rd;
        tick(3);
        total++;
        if (readdata !== 32'd0) begin
            bad++;
            $display("FAIL rst_readdata got=%h want=0", readdata);
        end
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("FAIL rst_irq got=%b want=0", irq);
        end
        total++;
        if (cop_start !== 1'b0) begin
            bad++;
            $display("FAIL rst_cop_start got=%b want=0", cop_start);
        end
        total++;
        if (cop_reset_n !== 1'b0) begin
            bad++;
            $display("FAIL rst_cop_reset_n got=%b want=0", cop_reset_n);
        end
        reset_n = 1'b1;
        @(negedge clk);
        total++;
        if (cop_reset_n !== 1'b0) begin
            bad++;
            $display("FAIL rst_release_early got=%b want=0", cop_reset_n);
        end
        @(posedge clk);
        #1;
        total++;
        if (cop_reset_n !== 1'b1) begin
            bad++;
            $display("FAIL rst_release_rise got=%b want=1", cop_reset_n);
        end
        for (int a = 0; a < 4; a++) begin
            bus_read(2'(a), rd);
            total++;
            if (rd !== 32'd0) begin
                bad++;
                $display("FAIL rst_reg%0d got=%h want=0", a, rd);
            end
        end
    endtask

    task automatic test_regs;
        logic [31:0] rd;
        logic [31:0] v;
        int bs;
        int bq;
        bs = n_start;
        bq = q_low.size();
        v = $urandom;
        bus_write(A_TMO, v);
        bus_read(A_TMO, rd);
        total++;
        if (rd !== v) begin
            bad++;
            $display("FAIL regs_timeout got=%h want=%h", rd, v);
        end
        bus_write(A_CTRL, 32'h7);
        tick(RST + 3);
        bus_read(A_CTRL, rd);
        total++;
        if (rd !== 32'h4) begin
            bad++;
            $display("FAIL regs_ctrl got=%h want=4", rd);
        end
        total++;
        if (n_start != bs || q_low.size() != bq) begin
            bad++;
            $display("FAIL regs_start_abort_idle starts=%0d lows=%0d want=0,0",
                     n_start - bs, q_low.size() - bq);
        end
        bus_write(A_CTRL, 32'h0);
        bus_read(A_CTRL, rd);
        total++;
        if (rd !== 32'h0) begin
            bad++;
            $display("FAIL regs_ctrl_clear got=%h want=0", rd);
        end
    endtask

    task automatic wait_start(input string tag);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 4 * RST + 10 && !got; i++) begin
            @(negedge clk);
            if (cop_start === 1'b1) got = 1'b1;
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL %s_start got=none want=pulse", tag);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        logic [31:0] rd;
        logic idle;
        idle = 1'b0;
        for (int i = 0; i < 400 && !idle; i++) begin
            bus_read(A_STS, rd);
            if (rd[0] === 1'b0) idle = 1'b1;
        end
        total++;
        if (!idle) begin
            bad++;
            $display("FAIL %s_idle got=busy want=idle", tag);
        end
    endtask

    // one run: flags appear in RUN cycle j; outcome from run-level model
    task automatic test_run(input int tmo, input int j, input logic [1:0] fl,
                            input logic ien, input string tag);
        logic [31:0] rd;
        logic [31:0] exp_sts;
        int exp_cyc;
        int seen;
        int n_low;
        int bs;
        int bq;
        bs = n_start;
        bq = q_low.size();
        bus_write(A_TMO, 32'(tmo));
        bus_write(A_CTRL, {29'd0, ien, 2'b01});
        wait_start(tag);
        tick(j - 1);
        cop_flags = fl;
        wait_idle(tag);
        cop_flags = 2'b00;
        tick(SYNC + 2);
        seen = j + SYNC;
        exp_sts = 32'd0;
        if (fl == 2'b00 || (tmo != 0 && tmo < seen)) begin
            exp_sts[2] = 1'b1;
            exp_cyc = tmo;
        end else begin
            exp_sts[3] = fl[1];
            exp_sts[1] = ~fl[1];
            exp_cyc = seen;
        end
        n_low = exp_sts[1] ? 1 : 2;
        bus_read(A_STS, rd);
        total++;
        if (rd !== exp_sts) begin
            bad++;
            $display("FAIL %s_status got=%h want=%h", tag, rd, exp_sts);
        end
        bus_read(A_CYC, rd);
        total++;
        if (rd !== 32'(exp_cyc)) begin
            bad++;
            $display("FAIL %s_cycles got=%0d want=%0d", tag, rd, exp_cyc);
        end
        total++;
        if (irq !== ien) begin
            bad++;
            $display("FAIL %s_irq got=%b want=%b", tag, irq, ien);
        end
        total++;
        if (n_start - bs != 1) begin
            bad++;
            $display("FAIL %s_nstart got=%0d want=1", tag, n_start - bs);
        end
        total++;
        if (q_low.size() - bq != n_low) begin
            bad++;
            $display("FAIL %s_nlow got=%0d want=%0d", tag, q_low.size() - bq,
                     n_low);
        end else begin
            for (int k = bq; k < q_low.size(); k++) begin
                total++;
                if (q_low[k] != RST) begin
                    bad++;
                    $display("FAIL %s_lowlen got=%0d want=%0d", tag, q_low[k],
                             RST);
                end
            end
        end
    endtask

    task automatic test_random_runs;
        int tmo;
        int j;
        logic [1:0] fl;
        logic ien;
        for (int n = 0; n < 10; n++) begin
            tmo = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 30);
            j   = $urandom_range(1, 25);
            fl  = 2'($urandom_range(0, 3));
            ien = 1'($urandom_range(0, 1));
            if (tmo == 0 && fl == 2'b00) fl = 2'b01;
            test_run(tmo, j, fl, ien, "rand");
        end
    endtask

    task automatic test_ignored_start_abort;
        logic [31:0] rd;
        int bs;
        int bq;
        bs = n_start;
        bq = q_low.size();
        bus_write(A_TMO, 32'd0);
        bus_write(A_CTRL, 32'h1);
        wait_start("ign");
        tick(3);
        bus_write(A_CTRL, 32'h1);
        tick(RST + 3);
        bus_read(A_STS, rd);
        total++;
        if (rd !== 32'h1 || n_start - bs != 1 || q_low.size() - bq != 1) begin
            bad++;
            $display("FAIL ign_start sts=%h starts=%0d lows=%0d want=1,1,1",
                     rd, n_start - bs, q_low.size() - bq);
        end
        bus_write(A_CTRL, 32'h3);
        wait_idle("ign");
        tick(3);
        bus_read(A_STS, rd);
        total++;
        if (rd !== 32'h0) begin
            bad++;
            $display("FAIL ign_abort_status got=%h want=0", rd);
        end
        total++;
        if (n_start - bs != 1 || q_low.size() - bq != 2) begin
            bad++;
            $display("FAIL ign_abort_pulses starts=%0d lows=%0d want=1,2",
                     n_start - bs, q_low.size() - bq);
        end else if (q_low[bq+1] != RST) begin
            bad++;
            $display("FAIL ign_abort_len got=%0d want=%0d", q_low[bq+1], RST);
        end
    endtask

    task automatic test_idle_abort;
        logic [31:0] rd;
        int bs;
        int bq;
        bs = n_start;
        bq = q_low.size();
        bus_write(A_CTRL, 32'h2);
        bus_write(A_CTRL, 32'h3);
        tick(RST + 3);
        bus_read(A_STS, rd);
        total++;
        if (rd !== 32'h0 || n_start != bs || q_low.size() != bq) begin
            bad++;
            $display("FAIL idle_abort sts=%h starts=%0d lows=%0d want=0,0,0",
                     rd, n_start - bs, q_low.size() - bq);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] rd;
        int bs;
        int bq;
        bs = n_start;
        bq = q_low.size();
        bus_write(A_CTRL, 32'h1);
        bus_write(A_CTRL, 32'h2);
        wait_idle("b2b");
        tick(3);
        total++;
        if (q_low.size() - bq != 1 || n_start != bs) begin
            bad++;
            $display("FAIL b2b_pulses lows=%0d starts=%0d want=1,0",
                     q_low.size() - bq, n_start - bs);
        end else if (q_low[bq] != RST + 1) begin
            bad++;
            $display("FAIL b2b_lowlen got=%0d want=%0d", q_low[bq], RST + 1);
        end
        bus_read(A_STS, rd);
        total++;
        if (rd !== 32'h0) begin
            bad++;
            $display("FAIL b2b_status got=%h want=0", rd);
        end
    endtask

    task automatic test_w1c;
        logic [31:0] rd;
        test_run(0, 3, 2'b01, 1'b1, "w1c");
        bus_write(A_STS, 32'h1);
        tick(2);
        bus_read(A_STS, rd);
        total++;
        if (rd !== 32'h2 || irq !== 1'b1) begin
            bad++;
            $display("FAIL w1c_busy_bit sts=%h irq=%b want=2,1", rd, irq);
        end
        bus_write(A_STS, 32'h2);
        tick(2);
        bus_read(A_STS, rd);
        total++;
        if (rd !== 32'h0) begin
            bad++;
            $display("FAIL w1c_done got=%h want=0", rd);
        end
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("FAIL w1c_irq got=%b want=0", irq);
        end
    endtask

    task automatic test_reset_mid_run;
        logic [31:0] rd;
        bus_write(A_TMO, 32'd50);
        bus_write(A_CTRL, 32'h5);
        wait_start("mid");
        tick(5);
        reset_n = 1'b0;
        #1;
        total++;
        if (readdata !== 32'd0 || irq !== 1'b0 || cop_start !== 1'b0 ||
            cop_reset_n !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_outs rd=%h irq=%b st=%b rn=%b want=0,0,0,0",
                     readdata, irq, cop_start, cop_reset_n);
        end
        tick(2);
        reset_n = 1'b1;
        tick(2);
        for (int a = 0; a < 4; a++) begin
            bus_read(2'(a), rd);
            total++;
            if (rd !== 32'd0) begin
                bad++;
                $display("FAIL mid_reset_reg%0d got=%h want=0", a, rd);
            end
        end
    endtask

    initial begin
        test_reset();
        test_regs();
        test_run(0, 10, 2'b01, 1'b1, "done10");
        test_run(20, 1, 2'b00, 1'b0, "tmo20");
        test_run(0, 5, 2'b11, 1'b1, "errdone");
        test_run(0, 4, 2'b10, 1'b0, "err");
        test_run(7, 5, 2'b01, 1'b0, "tie");
        test_run(1, 5, 2'b01, 1'b1, "tmo1");
        test_random_runs();
        test_ignored_start_abort();
        test_idle_abort();
        test_back_to_back();
        test_w1c();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
